serial_cond_encoder: RTL

Sequential, MSB-first magnitude comparator that produces condition codes. It is the inverse of the combinational set-condition unit: that unit takes a condition code and answers true or false, while this block takes two operands, scans them bit-serially and reports which condition codes hold. It sits beside the set-condition path in the lab ALU datapath as a low-area relation encoder, with a start/valid/ready handshake toward the sequencer.

---
 rtl/cond_pkg.sv | 30 +++
 rtl/cond_mask_gen.sv | 38 +++
 rtl/serial_cond_encoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_pkg
//  Description : Shared FSM states, set-condition indices and canonical
//                relation codes for the condition encoder/decoder pair.
//  Revision    : 1.0  initial release
// ============================================================================
package cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions in the condition mask; shared with the set-condition unit.
    localparam int COND_LE = 0;
    localparam int COND_LT = 1;
    localparam int COND_GE = 2;
    localparam int COND_GT = 3;
    localparam int COND_EQ = 4;
    localparam int COND_NE = 5;

    localparam logic [2:0] C_CODE_NONE = 3'b000;
    localparam logic [2:0] C_CODE_LT   = 3'b001;
    localparam logic [2:0] C_CODE_GT   = 3'b011;
    localparam logic [2:0] C_CODE_EQ   = 3'b100;

endpackage
`default_nettype wire

// File: rtl/cond_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cond_mask_gen
//  Description : Maps one-hot relation flags {lt, eq, gt} to the 6-bit
//                condition mask and canonical relation code.
//  Revision    : 1.0  initial release
// ============================================================================
module cond_mask_gen
    import cond_pkg::*;
(
    input  logic       en,
    input  logic       lt,
    input  logic       eq,
    input  logic       gt,
    output logic [2:0] code_out,
    output logic [5:0] mask
);

    always_comb begin
        code_out = C_CODE_NONE;
        mask     = '0;
        if (en) begin
            mask[COND_LE] = lt | eq;
            mask[COND_LT] = lt;
            mask[COND_GE] = gt | eq;
            mask[COND_GT] = gt;
            mask[COND_EQ] = eq;
            mask[COND_NE] = ~eq;
            // Priority order keeps code_out canonical even for illegal flag mixes.
            if (eq)      code_out = C_CODE_EQ;
            else if (gt) code_out = C_CODE_GT;
            else if (lt) code_out = C_CODE_LT;
            else         code_out = C_CODE_NONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_cond_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cond_encoder
//  Description : MSB-first bit-serial unsigned comparator reporting the full
//                set of true condition codes over a start/valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_cond_encoder
    import cond_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       code_out,
    output logic [5:0]       mask
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;
    logic             busy_q;
    logic             valid_q;

    logic             a_bit_w;
    logic             b_bit_w;

    assign a_bit_w = a_q[idx_q];
    assign b_bit_w = b_q[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        idx_q   <= IDX_W'(WIDTH - 1);
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // First differing bit from the MSB decides the relation.
                    if (a_bit_w && !b_bit_w) begin
                        gt_q    <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (!a_bit_w && b_bit_w) begin
                        lt_q    <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (idx_q == '0) begin
                        eq_q    <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign res_valid = valid_q;

    cond_mask_gen u_mask_gen (
        .en       (valid_q),
        .lt       (lt_q),
        .eq       (eq_q),
        .gt       (gt_q),
        .code_out (code_out),
        .mask     (mask)
    );

endmodule
`default_nettype wire
